// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between instruction fetch (read-only)
// and the memory stage (read/write). Data requests win arbitration because they
// belong to the older instruction. Each access runs a registered req/ack
// handshake, ends with one DONE cycle carrying the valid pulse, and can be
// aborted by a timeout that raises bus_err.
// Optional build macro ARB_STATS_EN adds fetch-stall and data-grant counters.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic        clk,
    input  logic        rst,
    // fetch side
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_valid,
    output logic        o_if_stall,
    // data side
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic [31:0] o_d_rdata,
    output logic        o_d_valid,
    output logic        o_d_stall,
    // memory port
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_bus_err
`ifdef ARB_STATS_EN
    ,
    output logic [31:0] o_stat_if_stall_cnt,
    output logic [31:0] o_stat_d_grant_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_D_BUSY  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // a fetch never writes, so its write data is forced to this value
    localparam logic [31:0] FETCH_WDATA = 32'd0;

    // registered state
    state_t      r_state;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic        r_if_valid;
    logic        r_d_valid;
    logic        r_bus_err;
    logic [31:0] r_tmo_cnt;

    // next-state values
    state_t      w_next_state;
    logic        w_mem_req;
    logic        w_mem_we;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic [31:0] w_if_rdata;
    logic [31:0] w_d_rdata;
    logic        w_if_valid;
    logic        w_d_valid;
    logic        w_bus_err;
    logic [31:0] w_tmo_cnt;

    logic        w_tmo_hit;
    logic        w_if_stall;
    logic        w_d_stall;

    // the current BUSY cycle is the last one allowed without an ack
    assign w_tmo_hit = (TIMEOUT_CYCLES != 32'd0) &&
                       ((r_tmo_cnt + 32'd1) == TIMEOUT_CYCLES);

    // a stage holds while its request is pending and its valid has not arrived
    assign w_if_stall = i_if_req && !r_if_valid;
    assign w_d_stall  = i_d_req && !r_d_valid;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next state, memory-port values, read-data capture and completion pulses
    always_comb begin
        w_next_state = r_state;
        w_mem_req    = r_mem_req;
        w_mem_we     = r_mem_we;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_if_rdata   = r_if_rdata;
        w_d_rdata    = r_d_rdata;
        w_if_valid   = 1'b0;
        w_d_valid    = 1'b0;
        w_bus_err    = 1'b0;
        w_tmo_cnt    = r_tmo_cnt;

        case (r_state)
            ST_IDLE: begin
                if (i_d_req) begin
                    w_mem_req    = 1'b1;
                    w_mem_we     = i_d_we;
                    w_mem_addr   = i_d_addr;
                    w_mem_wdata  = i_d_wdata;
                    w_tmo_cnt    = 32'd0;
                    w_next_state = ST_D_BUSY;
                end else if (i_if_req) begin
                    w_mem_req    = 1'b1;
                    w_mem_we     = 1'b0;
                    w_mem_addr   = i_if_addr;
                    w_mem_wdata  = FETCH_WDATA;
                    w_tmo_cnt    = 32'd0;
                    w_next_state = ST_IF_BUSY;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end

            ST_IF_BUSY: begin
                if (i_mem_ack) begin
                    w_mem_req    = 1'b0;
                    w_if_rdata   = i_mem_rdata;
                    w_if_valid   = 1'b1;
                    w_next_state = ST_DONE;
                end else if (w_tmo_hit) begin
                    w_mem_req    = 1'b0;
                    w_if_rdata   = 32'd0;
                    w_if_valid   = 1'b1;
                    w_bus_err    = 1'b1;
                    w_tmo_cnt    = r_tmo_cnt + 32'd1;
                    w_next_state = ST_DONE;
                end else begin
                    w_tmo_cnt    = r_tmo_cnt + 32'd1;
                end
            end

            ST_D_BUSY: begin
                if (i_mem_ack) begin
                    w_mem_req    = 1'b0;
                    // stores leave the load-data register untouched
                    if (!r_mem_we) begin
                        w_d_rdata = i_mem_rdata;
                    end else begin
                        w_d_rdata = r_d_rdata;
                    end
                    w_d_valid    = 1'b1;
                    w_next_state = ST_DONE;
                end else if (w_tmo_hit) begin
                    w_mem_req    = 1'b0;
                    w_d_rdata    = 32'd0;
                    w_d_valid    = 1'b1;
                    w_bus_err    = 1'b1;
                    w_tmo_cnt    = r_tmo_cnt + 32'd1;
                    w_next_state = ST_DONE;
                end else begin
                    w_tmo_cnt    = r_tmo_cnt + 32'd1;
                end
            end

            ST_DONE: begin
                // no grant here: the finished requester may still be holding
                // its request for this cycle and must not be served twice
                w_next_state = ST_IDLE;
            end

            default: begin
                w_mem_req    = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // datapath and pulse registers; reset also abandons any in-flight access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_if_rdata  <= 32'd0;
            r_d_rdata   <= 32'd0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_bus_err   <= 1'b0;
            r_tmo_cnt   <= 32'd0;
        end else begin
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_if_rdata  <= w_if_rdata;
            r_d_rdata   <= w_d_rdata;
            r_if_valid  <= w_if_valid;
            r_d_valid   <= w_d_valid;
            r_bus_err   <= w_bus_err;
            r_tmo_cnt   <= w_tmo_cnt;
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_if_stall_cnt;
    logic [31:0] r_stat_d_grant_cnt;
    logic        w_d_grant;

    assign w_d_grant = (r_state == ST_IDLE) && i_d_req;

    // free-running statistics counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_if_stall_cnt <= 32'd0;
            r_stat_d_grant_cnt  <= 32'd0;
        end else begin
            if (w_if_stall) begin
                r_stat_if_stall_cnt <= r_stat_if_stall_cnt + 32'd1;
            end else begin
                r_stat_if_stall_cnt <= r_stat_if_stall_cnt;
            end
            if (w_d_grant) begin
                r_stat_d_grant_cnt <= r_stat_d_grant_cnt + 32'd1;
            end else begin
                r_stat_d_grant_cnt <= r_stat_d_grant_cnt;
            end
        end
    end

    assign o_stat_if_stall_cnt = r_stat_if_stall_cnt;
    assign o_stat_d_grant_cnt  = r_stat_d_grant_cnt;
`endif

    assign o_if_rdata  = r_if_rdata;
    assign o_if_valid  = r_if_valid;
    assign o_if_stall  = w_if_stall;
    assign o_d_rdata   = r_d_rdata;
    assign o_d_valid   = r_d_valid;
    assign o_d_stall   = w_d_stall;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a vector table of single/dual-request scenarios
// against a programmable-latency memory responder, a scoreboard for returned
// data, and hand-written reset and post-reset sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = 32'd0;
    logic [31:0] o_if_rdata;
    logic        o_if_valid;
    logic        o_if_stall;
    logic        i_d_req = 1'b0;
    logic        i_d_we = 1'b0;
    logic [31:0] i_d_addr = 32'd0;
    logic [31:0] i_d_wdata = 32'd0;
    logic [31:0] o_d_rdata;
    logic        o_d_valid;
    logic        o_d_stall;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata = 32'hFFFF_FFFF;
    logic        i_mem_ack = 1'b0;
    logic        o_bus_err;
`ifdef ARB_STATS_EN
    logic [31:0] o_stat_if_stall_cnt;
    logic [31:0] o_stat_d_grant_cnt;
`endif

    mem_port_arbiter #(.TIMEOUT_CYCLES(32'd4)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata),
        .o_if_valid(o_if_valid), .o_if_stall(o_if_stall),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
        .o_d_rdata(o_d_rdata), .o_d_valid(o_d_valid), .o_d_stall(o_d_stall),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
        .o_bus_err(o_bus_err)
`ifdef ARB_STATS_EN
        , .o_stat_if_stall_cnt(o_stat_if_stall_cnt), .o_stat_d_grant_cnt(o_stat_d_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // memory contents model: never zero, distinct per address
    function automatic logic [31:0] mdl(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // memory responder: ack in the (ack_delay+1)-th cycle of mem_req
    int   ack_delay = 0;
    int   wait_cnt  = 0;
    logic resp_en   = 1'b1;
    logic force_ack = 1'b0;
    always @(posedge clk) begin
        #1;
        if (resp_en && o_mem_req) begin
            if (wait_cnt == ack_delay) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = mdl(o_mem_addr);
            end else begin
                i_mem_ack   = 1'b0;
                i_mem_rdata = 32'hFFFF_FFFF;
                wait_cnt++;
            end
        end else begin
            i_mem_ack   = force_ack;
            i_mem_rdata = 32'h1357_2468;
            wait_cnt    = 0;
        end
    end

    // scoreboard of expected completions, in completion order
    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } sb_t;
    sb_t sb_q[$];

    always @(negedge clk) begin
        sb_t e;
        if (o_if_valid || o_d_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_valid", {30'd0, o_d_valid, o_if_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_which", {31'd0, o_d_valid}, {31'd0, e.is_d});
                chk("sb_rdata", e.is_d ? o_d_rdata : o_if_rdata, e.rdata);
                chk("sb_bus_err", {31'd0, o_bus_err}, {31'd0, e.err});
            end
        end else if (o_bus_err) begin
            chk("bus_err_without_valid", {31'd0, o_bus_err}, 32'd0);
        end
    end

    typedef struct {
        logic        ifr;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        int          dly;
        logic        tmo;
        int          exp_d;
        int          exp_if;
        int          exp_mreq;
    } vec_t;

    logic [31:0] last_load = 32'd0;

    task automatic run_vec(input int idx, input vec_t v);
        int   d_cyc = -1;
        int   if_cyc = -1;
        int   stall_n = 0;
        int   mreq_n = 0;
        logic owner_d;
        sb_t  e;
        string nm;
`ifdef ARB_STATS_EN
        logic [31:0] s_stall0 = o_stat_if_stall_cnt;
        logic [31:0] s_grant0 = o_stat_d_grant_cnt;
`endif
        @(posedge clk); #1;
        ack_delay = v.dly;
        i_if_req = v.ifr; i_if_addr = v.ia;
        i_d_req = v.dr; i_d_we = v.dwe; i_d_addr = v.da; i_d_wdata = v.dwd;
        if (v.dr) begin
            e.is_d = 1'b1; e.err = v.tmo;
            if (v.tmo) e.rdata = 32'd0;
            else if (v.dwe) e.rdata = last_load;
            else e.rdata = mdl(v.da);
            last_load = e.rdata;
            sb_q.push_back(e);
        end
        if (v.ifr) begin
            e.is_d = 1'b0; e.err = v.tmo;
            e.rdata = v.tmo ? 32'd0 : mdl(v.ia);
            sb_q.push_back(e);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_if_stall) stall_n++;
            if (o_d_valid && d_cyc < 0) d_cyc = c;
            if (o_if_valid && if_cyc < 0) if_cyc = c;
            if (o_mem_req) begin
                mreq_n++;
                owner_d = v.dr && (d_cyc < 0);
                nm = $sformatf("v%0d_c%0d_mem", idx, c);
                chk({nm, "_addr"}, o_mem_addr, owner_d ? v.da : v.ia);
                chk({nm, "_we"}, {31'd0, o_mem_we}, {31'd0, owner_d && v.dwe});
                chk({nm, "_wdata"}, o_mem_wdata, owner_d ? v.dwd : 32'd0);
            end
            if ((!v.dr || d_cyc >= 0) && (!v.ifr || if_cyc >= 0)) break;
            @(posedge clk); #1;
            if (d_cyc >= 0) i_d_req = 1'b0;
            if (if_cyc >= 0) i_if_req = 1'b0;
        end
        @(posedge clk); #1;
        i_if_req = 1'b0; i_d_req = 1'b0;
        chk($sformatf("v%0d_d_valid_cycle", idx), d_cyc, v.exp_d);
        chk($sformatf("v%0d_if_valid_cycle", idx), if_cyc, v.exp_if);
        chk($sformatf("v%0d_if_stall_cycles", idx), stall_n, v.ifr ? v.exp_if : 0);
        chk($sformatf("v%0d_mem_req_cycles", idx), mreq_n, v.exp_mreq);
`ifdef ARB_STATS_EN
        chk($sformatf("v%0d_stat_if_stall", idx), o_stat_if_stall_cnt - s_stall0, stall_n);
        chk($sformatf("v%0d_stat_d_grant", idx), o_stat_d_grant_cnt - s_grant0, {31'd0, v.dr});
`endif
        repeat (2) @(posedge clk);
    endtask

    vec_t vecs[8];

    initial begin
        //          ifr   ia            dr    dwe   da            dwd            dly tmo   d  if mreq
        vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0,        32'h0,         0, 1'b0, -1, 2, 1};
        vecs[1] = '{1'b1, 32'h0000_0104, 1'b1, 1'b0, 32'h0000_0200, 32'h0,         0, 1'b0,  2, 5, 2};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 2, 1'b0,  4, -1, 3};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0080, 32'h0,         1, 1'b0,  3, -1, 2};
        vecs[4] = '{1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0,        32'h0,        99, 1'b1, -1, 5, 4};
        vecs[5] = '{1'b1, 32'h0000_0108, 1'b0, 1'b0, 32'h0,        32'h0,         3, 1'b0, -1, 5, 4};
        vecs[6] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0400, 32'h0,        99, 1'b1,  5, -1, 4};
        vecs[7] = '{1'b1, 32'h0000_010C, 1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678, 1, 1'b0,  3, 7, 4};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, o_mem_we}, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_mem_wdata", o_mem_wdata, 32'd0);
        chk("rst_if_rdata", o_if_rdata, 32'd0);
        chk("rst_d_rdata", o_d_rdata, 32'd0);
        chk("rst_pulses", {29'd0, o_if_valid, o_d_valid, o_bus_err}, 32'd0);
        chk("rst_stalls", {30'd0, o_if_stall, o_d_stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // reset in the middle of a fetch, then a stray ack for it
        @(negedge clk);
        resp_en = 1'b0;
        @(posedge clk); #1;
        i_if_req = 1'b1; i_if_addr = 32'h0000_0500;
        @(negedge clk);
        chk("rm_stall_c0", {31'd0, o_if_stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rm_mem_req_c1", {31'd0, o_mem_req}, 32'd1);
        chk("rm_mem_addr_c1", o_mem_addr, 32'h0000_0500);
        @(posedge clk); #1;
        rst = 1'b1; i_if_req = 1'b0;
        @(negedge clk);
        force_ack = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        force_ack = 1'b0;
        chk("rm_mem_req_after_rst", {31'd0, o_mem_req}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rm_quiet_%0d", c),
                {28'd0, o_mem_req, o_if_valid, o_d_valid, o_bus_err}, 32'd0);
        end
        @(negedge clk);
        resp_en = 1'b1;
        // a fresh fetch must see minimum latency again
        run_vec(8, '{1'b1, 32'h0000_0504, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, -1, 2, 1});

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the instruction-fetch stage (read-only) and the memory stage (read/write).
- Arbitrates requests, sequences the multi-cycle memory handshake and returns read data.
- Drives per-requester stall signals so each pipeline stage freezes until its access completes.
- Sits between the fetch/memory pipeline stages and the external memory port.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles waiting for mem_ack before aborting with bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch read request, held until if_valid
- if_addr  in  32  fetch address (PC)
- if_rdata  out  32  fetched word
- if_valid  out  1  one-cycle pulse, fetch access complete
- if_stall  out  1  fetch must hold (combinational)
- d_req  in  1  data request, held until d_valid
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data address
- d_wdata  in  32  write data
- d_rdata  out  32  load data
- d_valid  out  1  one-cycle pulse, data access complete
- d_stall  out  1  memory stage must hold (combinational)
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  32  memory address, registered
- mem_wdata  out  32  memory write data, registered
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion strobe
- bus_err  out  1  one-cycle pulse, access timed out

Behaviour:
- States: IDLE, IF_BUSY, D_BUSY, DONE.
- Reset:
  - State goes to IDLE.
  - mem_req, mem_we, if_valid, d_valid, bus_err go to 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata go to 0.
  - Timeout counter goes to 0.
- IDLE arbitration:
  - d_req has priority over if_req (older instruction first).
  - On grant: register addr/we/wdata onto mem_*, set mem_req=1, enter D_BUSY or IF_BUSY.
  - Fetch grants always drive mem_we=0 and mem_wdata=0.
- BUSY states:
  - mem_req and mem_* are held stable until the cycle mem_ack=1 is sampled.
  - On that edge: mem_req goes to 0, mem_rdata is captured into if_rdata or d_rdata (d_rdata unchanged for writes), state goes to DONE.
- DONE:
  - Exactly one cycle; the matching valid is high.
  - No grant is made in DONE, so a stale held request cannot be re-served.
  - Then return to IDLE.
- Minimum latency: request seen in cycle 0, mem_req high in cycle 1, ack in cycle 1 gives valid in cycle 2, next grant in cycle 3.
- if_stall = if_req && !if_valid; d_stall = d_req && !d_valid.
- Loser of a simultaneous request stays stalled and is granted in the next IDLE cycle.
- mem_ack is ignored in IDLE and DONE.
- Timeout:
  - The counter increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop mem_req, go to DONE, pulse valid and bus_err together, load 0 into the requester's rdata.
  - The counter clears on every grant.
- Reset mid-transaction: immediate IDLE with mem_req=0; any later ack for the aborted access is ignored.
- Request deasserted while its access is in flight: the access still completes and the valid pulse still occurs.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds outputs stat_if_stall_cnt[31:0] and stat_d_grant_cnt[31:0].
  - stat_if_stall_cnt increments each cycle if_stall=1.
  - stat_d_grant_cnt increments on each data grant.
  - Both reset to 0 and wrap at 2^32.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Fetch only: if_addr=0x100, mem_ack in first mem_req cycle -> mem_addr=0x100 one cycle after request; if_valid at request+2 cycles with if_rdata=mem_rdata; if_stall high for cycles 0-1.
- Simultaneous: if_req and d_req (read 0x200) together -> data served first, d_valid first; fetch to 0x104 granted in the IDLE cycle after DONE; if_stall stays high throughout.
- Store: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, ack after 3 cycles -> mem_we=1 and mem_wdata=0xDEADBEEF held stable 3 cycles; d_valid pulses once; d_rdata unchanged.
- Timeout: TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_req drops after 4 cycles; bus_err and if_valid pulse together; if_rdata=0.
- Reset mid-access: rst during IF_BUSY, then mem_ack one cycle after reset -> mem_req=0, no valid pulse, state IDLE.
- ARB_STATS_EN defined: run the simultaneous scenario -> stat_d_grant_cnt=1; stat_if_stall_cnt equals the counted if_stall-high cycles.
